pll_ctrl: RTL and testbench
===========================

PLL_CTRL -- requirements
Module: pll_ctrl

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles pll_rst is held high per PLL reset attempt.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before sys_reset releases.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: cycles in WAIT_LOCK before a PLL reset retry.
REQ-004 SHALL have parameters STEP_PULSE_CYCLES, default 4, and STEP_GAP_CYCLES, default 8: PHASESTEP low width and post-pulse gap.
REQ-005 SHALL have ports, clock and reset first: clk in 1 (free-running reference clock, never the PLL output); reset in 1 (asynchronous, active-high).
REQ-006 SHALL have ports: pll_locked in 1 (async PLL LOCK); pll_rst out 1 (PLL RST); sys_reset out 1 (active-high reset for downstream logic).
REQ-007 SHALL have ports: ps_req_valid in 1; ps_req_ready out 1; ps_sel in 2; ps_dir in 1; ps_steps in 4 (number of phase steps).
REQ-008 SHALL have ports: pll_phasesel out 2; pll_phasedir out 1; pll_phasestep out 1 (idle high); pll_phaseloadreg out 1; ps_busy out 1; lock_lost_cnt out 8.

Function
REQ-009 SHALL synchronize pll_locked through 2 flops; lock_ok is the synchronized value, and loss is flagged only after 2 consecutive low synchronized samples.
REQ-010 SHALL implement states RESET_PLL, WAIT_LOCK, RUN, PS_SETUP, PS_PULSE, PS_GAP.
REQ-011 RESET_PLL: pll_rst=1, sys_reset=1; after PLL_RST_CYCLES cycles -> WAIT_LOCK.
REQ-012 WAIT_LOCK: pll_rst=0; stability counter increments while lock_ok=1 and clears when lock_ok=0; when it reaches LOCK_STABLE_CYCLES -> RUN; when LOCK_TIMEOUT_CYCLES elapse first -> RESET_PLL.
REQ-013 sys_reset SHALL drop on the first cycle in RUN and remain low in RUN/PS_* states.
REQ-014 ps_req_ready SHALL be 1 only in RUN; a request is accepted on ps_req_valid&&ps_req_ready, latching sel/dir/steps.
REQ-015 Accepted ps_steps=0 SHALL produce no pulse; ready returns the next cycle.
REQ-016 Per step: PS_SETUP 1 cycle (pll_phasesel/pll_phasedir driven from the latched values); PS_PULSE STEP_PULSE_CYCLES with pll_phasestep=0; PS_GAP STEP_GAP_CYCLES with pll_phasestep=1; after the last gap -> RUN.
REQ-017 pll_phasesel/pll_phasedir SHALL hold their values from PS_SETUP through the last PS_GAP; ps_busy=1 in PS_* states.
REQ-018 pll_phaseloadreg SHALL be held at 1.
REQ-019 Loss of lock in RUN or PS_* SHALL, on the same cycle as it is flagged: set sys_reset=1, abort any phase step (pll_phasestep=1, ps_busy=0, ps_req_ready=0), increment lock_lost_cnt (saturating at 255), and go to RESET_PLL.
REQ-020 A loss of lock and a request acceptance in the same cycle SHALL resolve as loss of lock; the request is not accepted.

Reset
REQ-021 reset SHALL asynchronously force state RESET_PLL, counters 0, pll_rst=1, sys_reset=1, ps_req_ready=0, ps_busy=0, pll_phasestep=1, pll_phaseloadreg=1, pll_phasesel=0, pll_phasedir=0, lock_lost_cnt=0, and synchronizer flops 0.
REQ-022 Reset asserted mid-step SHALL end the pulse immediately (pll_phasestep=1); on release, the sequence restarts at RESET_PLL.

Configuration
REQ-023 With macro PLL_CTRL_PHASE_STEP_EN defined: the phase-step logic is as specified above.
REQ-024 Without PLL_CTRL_PHASE_STEP_EN: no PS_* states; pll_phasestep=1; pll_phasesel=0; pll_phasedir=0; ps_busy=0; ps_req_ready=1 in RUN, with requests acknowledged and discarded.

Structure
REQ-025 Package pll_ctrl_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-026 Sub-module pll_ctrl_lock_sync SHALL hold the 2-flop synchronizer and the 2-sample loss filter.

Verification (bench params: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=16, LOCK_TIMEOUT_CYCLES=64, STEP_PULSE_CYCLES=2, STEP_GAP_CYCLES=3)
REQ-027 Release reset, pll_locked=1 from cycle 0 -> pll_rst high for 4 cycles; sys_reset falls 2+16 cycles after pll_rst falls (±1).
REQ-028 pll_locked held 0 -> pll_rst re-pulses every 4+64 cycles; sys_reset stays 1.
REQ-029 In RUN, request sel=2, dir=1, steps=3 -> 3 pll_phasestep low pulses, each 2 cycles wide, with pll_phasesel=2 and pll_phasedir=1 throughout; ready returns 1 after 3*(1+2+3) cycles.
REQ-030 pll_locked 1-cycle low glitch in RUN -> no reaction; 3-cycle low -> sys_reset=1, lock_lost_cnt=1, RESET_PLL.
REQ-031 Lock lost during the 2nd step pulse -> pll_phasestep=1 the same cycle loss is flagged, ps_busy=0, lock_lost_cnt increments; 256 losses -> lock_lost_cnt=255.
REQ-032 Build without PLL_CTRL_PHASE_STEP_EN, request steps=5 -> accepted in 1 cycle; pll_phasestep stays 1.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// PLL reset/lock sequencer: shared state type, default timing and helpers.
package pll_ctrl_pkg;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_STEP_PULSE_CYCLES   = 4;
    localparam int DEF_STEP_GAP_CYCLES     = 8;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        RUN,
        PS_SETUP,
        PS_PULSE,
        PS_GAP
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_ctrl_lock_sync.sv
// Two-flop synchronizer for PLL LOCK plus a two-sample loss-of-lock filter.
module pll_ctrl_lock_sync (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic pll_locked,
    output logic lock_ok,
    output logic lock_lost
);

    logic meta;
    logic sync;
    logic prev;

    // clr discards stale lock while the PLL itself is held in reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else if (clr) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= pll_locked;
            sync <= meta;
            prev <= sync;
        end
    end

    assign lock_ok   = sync;
    assign lock_lost = ~sync & ~prev;

endmodule

// File: rtl/pll_ctrl.sv
// PLL reset/lock sequencer with optional dynamic phase stepping.
// Phase stepping is built only when PLL_CTRL_PHASE_STEP_EN is defined.
module pll_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int STEP_PULSE_CYCLES   = DEF_STEP_PULSE_CYCLES,
    parameter int STEP_GAP_CYCLES     = DEF_STEP_GAP_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    input  logic       ps_req_valid,
    output logic       ps_req_ready,
    input  logic [1:0] ps_sel,
    input  logic       ps_dir,
    input  logic [3:0] ps_steps,
    output logic [1:0] pll_phasesel,
    output logic       pll_phasedir,
    output logic       pll_phasestep,
    output logic       pll_phaseloadreg,
    output logic       ps_busy,
    output logic [7:0] lock_lost_cnt
);

    localparam int CW = $clog2(PLL_RST_CYCLES + STEP_PULSE_CYCLES
                               + STEP_GAP_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] stab;
    logic [TW-1:0] tmo;
    logic          rst_q;
    logic          sysrst_q;
    logic          ready_q;
    logic          busy_q;
    logic          step_q;
    logic [1:0]    sel_q;
    logic          dir_q;
    logic [7:0]    lost_q;
    logic          lock_ok;
    logic          lock_lost;
    logic          in_run;
    logic          abort;

`ifdef PLL_CTRL_PHASE_STEP_EN
    logic [3:0]    rem;
    logic          accept;
    assign accept = ps_req_valid & ps_req_ready;
`else
    logic          unused_ps;
    assign unused_ps = ^{ps_req_valid, ps_sel, ps_dir, ps_steps};
`endif

    pll_ctrl_lock_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .clr       (rst_q),
        .pll_locked(pll_locked),
        .lock_ok   (lock_ok),
        .lock_lost (lock_lost)
    );

    assign in_run = (state == RUN) || (state == PS_SETUP)
                 || (state == PS_PULSE) || (state == PS_GAP);
    // loss overrides the registered outputs in the very cycle it is seen
    assign abort  = lock_lost & in_run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RESET_PLL;
            cnt      <= '0;
            stab     <= '0;
            tmo      <= '0;
            rst_q    <= 1'b1;
            sysrst_q <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            step_q   <= 1'b1;
            sel_q    <= 2'd0;
            dir_q    <= 1'b0;
            lost_q   <= 8'd0;
`ifdef PLL_CTRL_PHASE_STEP_EN
            rem      <= 4'd0;
`endif
        end else if (abort) begin
            state    <= RESET_PLL;
            cnt      <= '0;
            rst_q    <= 1'b1;
            sysrst_q <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            step_q   <= 1'b1;
            sel_q    <= 2'd0;
            dir_q    <= 1'b0;
            lost_q   <= sat_inc8(lost_q);
        end else begin
            unique case (state)
                RESET_PLL: begin
                    if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                        stab  <= '0;
                        tmo   <= '0;
                        rst_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_ok && stab == SW'(LOCK_STABLE_CYCLES - 1)) begin
                        state    <= RUN;
                        sysrst_q <= 1'b0;
                        ready_q  <= 1'b1;
                    end else if (tmo == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        state <= RESET_PLL;
                        cnt   <= '0;
                        rst_q <= 1'b1;
                    end else begin
                        tmo  <= tmo + TW'(1);
                        stab <= lock_ok ? stab + SW'(1) : '0;
                    end
                end
                RUN: begin
`ifdef PLL_CTRL_PHASE_STEP_EN
                    if (accept && ps_steps != 4'd0) begin
                        state   <= PS_SETUP;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        sel_q   <= ps_sel;
                        dir_q   <= ps_dir;
                        rem     <= ps_steps;
                    end
`endif
                end
`ifdef PLL_CTRL_PHASE_STEP_EN
                PS_SETUP: begin
                    state  <= PS_PULSE;
                    cnt    <= '0;
                    step_q <= 1'b0;
                end
                PS_PULSE: begin
                    if (cnt == CW'(STEP_PULSE_CYCLES - 1)) begin
                        state  <= PS_GAP;
                        cnt    <= '0;
                        step_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PS_GAP: begin
                    if (cnt == CW'(STEP_GAP_CYCLES - 1)) begin
                        cnt <= '0;
                        if (rem == 4'd1) begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            sel_q   <= 2'd0;
                            dir_q   <= 1'b0;
                        end else begin
                            state <= PS_SETUP;
                            rem   <= rem - 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                default: begin
                    state    <= RESET_PLL;
                    cnt      <= '0;
                    rst_q    <= 1'b1;
                    sysrst_q <= 1'b1;
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    step_q   <= 1'b1;
                end
            endcase
        end
    end

    assign pll_rst          = rst_q;
    assign sys_reset        = sysrst_q | abort;
    assign ps_req_ready     = ready_q & ~abort;
    assign ps_busy          = busy_q & ~abort;
    assign pll_phasestep    = step_q | abort;
    assign pll_phasesel     = sel_q;
    assign pll_phasedir     = dir_q;
    assign pll_phaseloadreg = 1'b1;
    assign lock_lost_cnt    = lost_q;

endmodule

// File: tb/tb_pll_ctrl.sv
// Self-checking bench for pll_ctrl: timing arithmetic and a lock-loss model.
// Covers both builds; phase-step checks follow PLL_CTRL_PHASE_STEP_EN.
module tb_pll_ctrl;

    localparam int P_RST  = 4;
    localparam int P_STAB = 16;
    localparam int P_TMO  = 64;
    localparam int P_PUL  = 2;
    localparam int P_GAP  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_reset;
    logic       ps_req_valid = 1'b0;
    logic       ps_req_ready;
    logic [1:0] ps_sel = 2'd0;
    logic       ps_dir = 1'b0;
    logic [3:0] ps_steps = 4'd0;
    logic [1:0] pll_phasesel;
    logic       pll_phasedir;
    logic       pll_phasestep;
    logic       pll_phaseloadreg;
    logic       ps_busy;
    logic [7:0] lock_lost_cnt;

    int n_vec = 0;
    int n_err = 0;
    int mdl_lost = 0;
    int sr_drop = 0;

    pll_ctrl #(
        .PLL_RST_CYCLES     (P_RST),
        .LOCK_STABLE_CYCLES (P_STAB),
        .LOCK_TIMEOUT_CYCLES(P_TMO),
        .STEP_PULSE_CYCLES  (P_PUL),
        .STEP_GAP_CYCLES    (P_GAP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .pll_rst         (pll_rst),
        .sys_reset       (sys_reset),
        .ps_req_valid    (ps_req_valid),
        .ps_req_ready    (ps_req_ready),
        .ps_sel          (ps_sel),
        .ps_dir          (ps_dir),
        .ps_steps        (ps_steps),
        .pll_phasesel    (pll_phasesel),
        .pll_phasedir    (pll_phasedir),
        .pll_phasestep   (pll_phasestep),
        .pll_phaseloadreg(pll_phaseloadreg),
        .ps_busy         (ps_busy),
        .lock_lost_cnt   (lock_lost_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (pll_rst === lvl && n < 1000) begin
            n++;
            if (!sys_reset) sr_drop++;
            @(negedge clk);
        end
    endtask

    task automatic wait_run();
        int n = 0;
        while (sys_reset && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("relock", 32'(sys_reset), 32'd0);
    endtask

    task automatic lose(input int len);
        pll_locked = 1'b0;
        repeat (len) @(negedge clk);
        pll_locked = 1'b1;
    endtask

`ifdef PLL_CTRL_PHASE_STEP_EN
    task automatic do_req(input logic [1:0] s, input logic d,
                          input logic [3:0] k);
        int n = 0;
        int low = 0;
        int pulses = 0;
        int bad = 0;
        logic prev = 1'b1;
        chk("req_ready", 32'(ps_req_ready), 32'd1);
        ps_sel = s;
        ps_dir = d;
        ps_steps = k;
        ps_req_valid = 1'b1;
        @(negedge clk);
        ps_req_valid = 1'b0;
        while (!ps_req_ready && n < 300) begin
            n++;
            if (!ps_busy || pll_phasesel != s || pll_phasedir != d) bad++;
            if (!pll_phasestep) begin
                low++;
                if (prev) pulses++;
            end
            prev = pll_phasestep;
            @(negedge clk);
        end
        chk("step_busy_len", 32'(n), 32'(int'(k) * (1 + P_PUL + P_GAP)));
        chk("step_pulses", 32'(pulses), 32'(k));
        chk("step_low", 32'(low), 32'(int'(k) * P_PUL));
        chk("step_selhold", 32'(bad), 32'd0);
        chk("step_idle", 32'({ps_busy, pll_phasestep}), 32'b01);
    endtask
`endif

    initial begin
        int n;
        int d;
        int len;
        logic exp_loss;

        // reset state, lock present from the start
        pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pll_rst", 32'(pll_rst), 32'd1);
        chk("rst_sys_reset", 32'(sys_reset), 32'd1);
        chk("rst_ready", 32'(ps_req_ready), 32'd0);
        chk("rst_busy", 32'(ps_busy), 32'd0);
        chk("rst_step", 32'(pll_phasestep), 32'd1);
        chk("rst_loadreg", 32'(pll_phaseloadreg), 32'd1);
        chk("rst_seldir", 32'({pll_phasesel, pll_phasedir}), 32'd0);
        chk("rst_lostcnt", 32'(lock_lost_cnt), 32'd0);

        reset = 1'b0;
        run_len(1'b1, n);
        chk("pll_rst_width", 32'(n), 32'(P_RST));
        d = 0;
        while (sys_reset && d < 500) begin
            d++;
            @(negedge clk);
        end
        chk("sysrst_delay", 32'(d), 32'(2 + P_STAB));
        chk("run_ready", 32'(ps_req_ready), 32'd1);

        // no lock: periodic PLL reset retries
        reset = 1'b1;
        pll_locked = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        sr_drop = 0;
        run_len(1'b1, n);
        chk("retry_hi0", 32'(n), 32'(P_RST));
        for (int i = 0; i < 2; i++) begin
            run_len(1'b0, n);
            chk("retry_lo", 32'(n), 32'(P_TMO));
            run_len(1'b1, n);
            chk("retry_hi", 32'(n), 32'(P_RST));
        end
        chk("retry_sysrst", 32'(sr_drop), 32'd0);
        pll_locked = 1'b1;
        wait_run();

        // single-cycle glitch is filtered
        lose(1);
        repeat (4) @(negedge clk);
        chk("glitch_sysrst", 32'(sys_reset), 32'd0);
        chk("glitch_cnt", 32'(lock_lost_cnt), 32'(mdl_lost));

        // three-cycle loss
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        chk("loss3_sysrst", 32'(sys_reset), 32'd1);
        chk("loss3_ready", 32'(ps_req_ready), 32'd0);
        pll_locked = 1'b1;
        mdl_lost++;
        @(negedge clk);
        chk("loss3_cnt", 32'(lock_lost_cnt), 32'(mdl_lost));
        chk("loss3_pll_rst", 32'(pll_rst), 32'd1);
        wait_run();

        // random low-pulse lengths: loss iff two or more cycles low
        for (int i = 0; i < 8; i++) begin
            len = $urandom_range(1, 4);
            exp_loss = (len >= 2);
            lose(len);
            repeat (4) @(negedge clk);
            chk("rnd_sysrst", 32'(sys_reset), 32'(exp_loss));
            if (exp_loss) mdl_lost++;
            chk("rnd_cnt", 32'(lock_lost_cnt), 32'(mdl_lost));
            if (exp_loss) wait_run();
        end

`ifdef PLL_CTRL_PHASE_STEP_EN
        do_req(2'd2, 1'b1, 4'd3);
        do_req(2'd1, 1'b0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            do_req(2'($urandom), 1'($urandom), 4'($urandom_range(1, 6)));
        end

        // loss during the second pulse
        ps_sel = 2'd3;
        ps_dir = 1'b1;
        ps_steps = 4'd3;
        ps_req_valid = 1'b1;
        @(negedge clk);
        ps_req_valid = 1'b0;
        @(negedge clk);
        chk("abort_p1", 32'(pll_phasestep), 32'd0);
        repeat (3) @(negedge clk);
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_step", 32'(pll_phasestep), 32'd1);
        chk("abort_busy", 32'(ps_busy), 32'd0);
        chk("abort_ready", 32'(ps_req_ready), 32'd0);
        chk("abort_sysrst", 32'(sys_reset), 32'd1);
        pll_locked = 1'b1;
        mdl_lost++;
        @(negedge clk);
        chk("abort_cnt", 32'(lock_lost_cnt), 32'(mdl_lost));
        wait_run();

        // reset asserted mid-pulse
        ps_steps = 4'd2;
        ps_req_valid = 1'b1;
        @(negedge clk);
        ps_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_pulse", 32'(pll_phasestep), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_step", 32'(pll_phasestep), 32'd1);
        chk("mid_rst_busy", 32'(ps_busy), 32'd0);
        chk("mid_rst_pll", 32'(pll_rst), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        mdl_lost = 0;
        wait_run();
`else
        ps_steps = 4'd5;
        ps_req_valid = 1'b1;
        chk("nops_ready", 32'(ps_req_ready), 32'd1);
        @(negedge clk);
        ps_req_valid = 1'b0;
        chk("nops_ready_next", 32'(ps_req_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (!pll_phasestep || ps_busy || pll_phasesel != 2'd0) n++;
            @(negedge clk);
        end
        chk("nops_idle", 32'(n), 32'd0);
`endif

        // saturation of the loss counter
        while (mdl_lost < 257) begin
            lose(3);
            mdl_lost++;
            @(negedge clk);
            chk("sat_cnt", 32'(lock_lost_cnt), 32'(sat255(mdl_lost)));
            wait_run();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
